// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx
// Framed serial source for a Mealy "1001" detector. A frame is the sync
// preamble 1,0,0,1, then a WIDTH-bit word sent MSB-first, then GAP zeros.
// busy covers the whole frame, sync marks the final preamble bit, and done
// marks the last gap bit. All outputs are registered.
//
// Request semantics: start acts as a one-sided valid with an implicit ready
// that is high only in IDLE. A start seen at an edge while IDLE is accepted
// and data is captured on that same edge. A start at any other time, including
// the done cycle, is dropped and never queued.
module serial_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    output logic             w,
    output logic             busy,
    output logic             done,
    output logic             sync
);

    // The counter must hold the longest phase length: preamble (4), payload
    // (WIDTH) or gap (GAP).
    localparam int CNT_MAX = (WIDTH > GAP) ? ((WIDTH > 4) ? WIDTH : 4)
                                           : ((GAP > 4) ? GAP : 4);
    localparam int CW      = $clog2(CNT_MAX + 1);

    // Each state names the frame phase whose bit is on w during the current
    // cycle. state is kept as a plain named signal so a checker can bind to it.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_n;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_n;
    logic             w_n;
    logic             busy_n;
    logic             done_n;
    logic             sync_n;

    // State, counter, payload and output registers. Reset is asynchronous,
    // so a frame in flight is abandoned at once without a done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            shreg <= '0;
            w     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sync  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            shreg <= shreg_n;
            w     <= w_n;
            busy  <= busy_n;
            done  <= done_n;
            sync  <= sync_n;
        end
    end

    // Next-state logic. Output values are computed one edge ahead, because
    // they describe the cycle that the next state will occupy. cnt counts
    // down the bits that are still to come in the current phase.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shreg_n = shreg;
        w_n     = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        sync_n  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    // Preamble bit 0 (a 1) goes out in the cycle after acceptance.
                    state_n = ST_PRE;
                    cnt_n   = CW'(3);
                    shreg_n = data;
                    w_n     = 1'b1;
                    busy_n  = 1'b1;
                end
            end

            ST_PRE: begin
                busy_n = 1'b1;
                if (cnt != '0) begin
                    // Preamble bits 1 and 2 are 0. Bit 3 is 1 and carries sync.
                    cnt_n  = cnt - CW'(1);
                    w_n    = (cnt == CW'(1));
                    sync_n = (cnt == CW'(1));
                end else begin
                    state_n = ST_DATA;
                    cnt_n   = CW'(WIDTH - 1);
                    w_n     = shreg[WIDTH-1];
                    shreg_n = shreg << 1;
                end
            end

            ST_DATA: begin
                busy_n = 1'b1;
                if (cnt != '0) begin
                    cnt_n   = cnt - CW'(1);
                    w_n     = shreg[WIDTH-1];
                    shreg_n = shreg << 1;
                end else begin
                    // A single-cycle gap makes its first cycle the done cycle.
                    state_n = ST_GAP;
                    cnt_n   = CW'(GAP - 1);
                    done_n  = (GAP == 1);
                end
            end

            ST_GAP: begin
                if (cnt != '0) begin
                    busy_n = 1'b1;
                    cnt_n  = cnt - CW'(1);
                    done_n = (cnt == CW'(1));
                end else begin
                    // Return to IDLE for at least one cycle. Any start seen
                    // now is dropped.
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end
            end

            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

endmodule
